trafficlight_monitor: RTL and testbench
=======================================

# trafficlight_monitor

Safety monitor and lamp driver on the output side of `trafficlight_controller`. It samples the controller's 2-bit `hwy`/`road` light codes every clock and decodes them into one-hot lamp drives. It tracks the expected phase sequence and latches the first safety violation it detects. While a fault is latched it forces both roads to flashing red, so an unsafe code pair never reaches the lamps.

## Interface
- `MIN_YELLOW`, default 3: minimum consecutive cycles a yellow phase must be sampled before it is left.
- `FLASH_HALF`, default 4: cycles per half-period of the fault flashing-red pattern.
- `DWELL_W`, default 8: width of the dwell counter.

Ports (clock and reset first):
- `clock` in 1: single clock; all state updates on rising edge.
- `clear_n` in 1: reset, asynchronous, active-low.
- `hwy` in 2: highway light code from the controller; 00 RED, 01 GREEN, 10 YELLOW, 11 illegal.
- `road` in 2: road light code, same encoding as `hwy`.
- `fault_ack` in 1: single-cycle synchronous request to clear a latched fault.
- `hwy_lamp` out 3: highway lamp drive {red, yellow, green}, registered.
- `road_lamp` out 3: road lamp drive {red, yellow, green}, registered.
- `fault` out 1: sticky fault flag.
- `fault_code` out 3: cause of the latched fault; 0 when no fault.
- `phase` out 3: tracked phase; 0 HG, 1 HY, 2 AR, 3 RG, 4 RY, 5 INIT, 6 FAULT.
- `dwell` out DWELL_W: consecutive cycles in the current phase, saturating.

## Operation
- Pair-to-phase mapping: (01,00)=HG, (10,00)=HY, (00,00)=AR, (00,01)=RG, (00,10)=RY. Any other pair is a fault.
- Legal moves are staying in the same phase, HG->HY, HY->AR, AR->RG, RG->RY and RY->HG.
- INIT adopts the first valid pair sampled, whatever phase it maps to. No transition check is made on that first pair.
- Fault detection on each sampled pair, in priority order (highest first):
  - code 1: illegal encoding, i.e. 11 on `hwy` or `road`.
  - code 2: conflict, i.e. both codes non-red.
  - code 3: illegal transition between valid phases.
  - code 4: short yellow, i.e. leaving HY or RY while `dwell` < `MIN_YELLOW`.
- Only the highest-priority cause is reported.
- On detection:
  - `fault` goes to 1, `fault_code` loads the cause, and `phase` goes to FAULT.
  - Further violations while in FAULT do not change `fault_code`, so the first fault wins.
  - Inputs are ignored in FAULT except through `fault_ack`.
- Normal lamp decode: 00->100, 01->001, 10->010.
- FAULT lamps:
  - Both lamps show flashing red: 100 for `FLASH_HALF` cycles, then 000 for `FLASH_HALF` cycles, repeating.
  - The first flash-on period starts on the detection edge.
  - Yellow and green are never driven in FAULT.
- `fault_ack` while in FAULT clears `fault` and `fault_code`, sets `phase` to INIT, resets the flash counter and sets `dwell` to 0. It is ignored outside FAULT.
- `fault_ack` in the same cycle as a new violation, while not in FAULT: the fault is latched normally.
- Dwell counter:
  - Set to 1 on the edge a new phase is entered.
  - Increments each cycle the phase is unchanged.
  - Saturates at 2^DWELL_W-1.
  - Held at 0 in INIT and FAULT.
- Short-yellow check compares the pre-update `dwell`. A saturated `dwell` always passes.

## Timing
- Reset values, applied asynchronously on `clear_n`=0:
  - `hwy_lamp`=100, `road_lamp`=100 (steady red).
  - `fault`=0, `fault_code`=0.
  - `phase`=5 (INIT), `dwell`=0.
  - Flash counter 0.
- Reset asserted mid-fault or mid-phase discards all state.
- Latency is one cycle from input pair to all outputs.
- On the detection edge, lamps load 100/100 instead of the decoded unsafe value. A conflicting pair therefore never appears on the lamps.
- The first sampled pair after reset or after ack is checked for encoding and conflict only.
- `fault_ack` takes effect on the edge it is sampled. The pair sampled on the following edge is the one adopted by INIT.

## Test plan
- Assert `clear_n`=0 mid-RG, between edges. Required: lamps 100/100, `fault`=0 and `phase`=5 immediately, with no clock edge. After release, the first pair (01,00) gives `phase`=0 and `dwell`=1.
- Legal cycle HG×5, HY×3, AR×2, RG×4, RY×3, HG. Required:
  - Lamps follow one cycle late (HG gives `hwy_lamp`=001, `road_lamp`=100).
  - `dwell` reaches 5 before HY.
  - `fault` stays 0 throughout.
- Drive `hwy`=01, `road`=01 from HG. Required:
  - Next edge: `fault`=1, `fault_code`=2, lamps 100/100.
  - Lamps go to 000/000 after 4 cycles and back to 100/100 after 8 cycles.
- With `MIN_YELLOW`=3, go HG, HY×2, AR. Required: `fault_code`=4 on the AR edge. The same test with HY×3 gives no fault.
- Go HG->AR directly, giving `fault_code`=3. Then `road`=11, giving `fault_code` still 3. Then pulse `fault_ack`. Required:
  - `fault`=0, `phase`=5, `dwell`=0.
  - The next pair (00,01) is adopted as RG with no fault.
- Drive `hwy`=10, `road`=11. Required: `fault_code`=1, because encoding outranks conflict. A `fault_ack` pulse in the same cycle as the violation does not prevent the latch.

Source files
------------

// File: rtl/trafficlight_monitor.sv
// Safety monitor / lamp driver: decodes hwy/road codes to lamps, tracks phase order, latches the first fault.
// Latency: one cycle from sampled input pair to every output (all outputs registered).
// Backpressure: none; a new pair is sampled every clock and fault_ack is the only input honoured in FAULT.
module trafficlight_monitor #(
    parameter int MIN_YELLOW = 3,
    parameter int FLASH_HALF = 4,
    parameter int DWELL_W    = 8
) (
    input  logic               clock,
    input  logic               clear_n,
    input  logic [1:0]         hwy,
    input  logic [1:0]         road,
    input  logic               fault_ack,
    output logic [2:0]         hwy_lamp,
    output logic [2:0]         road_lamp,
    output logic               fault,
    output logic [2:0]         fault_code,
    output logic [2:0]         phase,
    output logic [DWELL_W-1:0] dwell
);

    localparam logic [2:0] PH_HG    = 3'd0;
    localparam logic [2:0] PH_HY    = 3'd1;
    localparam logic [2:0] PH_AR    = 3'd2;
    localparam logic [2:0] PH_RG    = 3'd3;
    localparam logic [2:0] PH_RY    = 3'd4;
    localparam logic [2:0] PH_INIT  = 3'd5;
    localparam logic [2:0] PH_FAULT = 3'd6;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    localparam logic [DWELL_W-1:0] DWELL_MAX = '1;

    // Flash counter spans one full on/off period
    localparam int             FLASH_W      = (FLASH_HALF > 1) ? $clog2(2 * FLASH_HALF) : 1;
    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(2 * FLASH_HALF - 1);
    localparam logic [FLASH_W-1:0] FLASH_OFF  = FLASH_W'(FLASH_HALF);

    logic [FLASH_W-1:0] flash_cnt;
    logic [FLASH_W-1:0] flash_nxt;
    logic [2:0]         phase_nxt;
    logic [DWELL_W-1:0] dwell_nxt;
    logic               fault_nxt;
    logic [2:0]         code_nxt;
    logic [2:0]         det_code;
    logic [2:0]         pair_ph;
    logic [2:0]         succ_ph;
    logic               enc_bad;
    logic               conflict;
    logic [2:0]         hwy_lamp_nxt;
    logic [2:0]         road_lamp_nxt;

    function automatic logic [2:0] decode_lamp(input logic [1:0] c);
        case (c)
            2'b01:   return 3'b001;
            2'b10:   return 3'b010;
            default: return LAMP_RED;
        endcase
    endfunction

    // Classify the sampled pair and find the legal successor of the tracked phase
    always_comb begin
        enc_bad  = (hwy == 2'b11) || (road == 2'b11);
        conflict = (hwy != 2'b00) && (road != 2'b00);
        case ({hwy, road})
            4'b0100: pair_ph = PH_HG;
            4'b1000: pair_ph = PH_HY;
            4'b0000: pair_ph = PH_AR;
            4'b0001: pair_ph = PH_RG;
            4'b0010: pair_ph = PH_RY;
            default: pair_ph = PH_FAULT;
        endcase
        case (phase)
            PH_HG:   succ_ph = PH_HY;
            PH_HY:   succ_ph = PH_AR;
            PH_AR:   succ_ph = PH_RG;
            PH_RG:   succ_ph = PH_RY;
            PH_RY:   succ_ph = PH_HG;
            default: succ_ph = PH_INIT;
        endcase
    end

    // State register: phase, dwell, fault latch, flash counter and lamp drives
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            phase      <= PH_INIT;
            dwell      <= '0;
            fault      <= 1'b0;
            fault_code <= 3'd0;
            flash_cnt  <= '0;
            hwy_lamp   <= LAMP_RED;
            road_lamp  <= LAMP_RED;
        end else begin
            phase      <= phase_nxt;
            dwell      <= dwell_nxt;
            fault      <= fault_nxt;
            fault_code <= code_nxt;
            flash_cnt  <= flash_nxt;
            hwy_lamp   <= hwy_lamp_nxt;
            road_lamp  <= road_lamp_nxt;
        end
    end

    // Next state: prioritised fault detection, phase tracking and dwell counting
    always_comb begin
        phase_nxt = phase;
        dwell_nxt = dwell;
        fault_nxt = fault;
        code_nxt  = fault_code;
        flash_nxt = flash_cnt;
        det_code  = 3'd0;
        if (phase == PH_FAULT) begin
            dwell_nxt = '0;
            if (fault_ack) begin
                phase_nxt = PH_INIT;
                fault_nxt = 1'b0;
                code_nxt  = 3'd0;
                flash_nxt = '0;
            end else begin
                flash_nxt = (flash_cnt == FLASH_LAST) ? '0 : flash_cnt + 1'b1;
            end
        end else begin
            if (enc_bad) begin
                det_code = 3'd1;
            end else if (conflict) begin
                det_code = 3'd2;
            end else if (phase != PH_INIT && pair_ph != phase) begin
                // INIT adopts anything valid; otherwise only the successor is allowed
                if (pair_ph != succ_ph) begin
                    det_code = 3'd3;
                end else if ((phase == PH_HY || phase == PH_RY) &&
                             int'(dwell) < MIN_YELLOW && dwell != DWELL_MAX) begin
                    det_code = 3'd4;
                end
            end
            if (det_code != 3'd0) begin
                phase_nxt = PH_FAULT;
                fault_nxt = 1'b1;
                code_nxt  = det_code;
                dwell_nxt = '0;
                flash_nxt = '0;
            end else if (pair_ph == phase) begin
                dwell_nxt = (dwell == DWELL_MAX) ? dwell : dwell + 1'b1;
            end else begin
                phase_nxt = pair_ph;
                dwell_nxt = {{(DWELL_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Lamp outputs: flashing red in FAULT, steady red in INIT, otherwise decoded codes
    always_comb begin
        hwy_lamp_nxt  = LAMP_RED;
        road_lamp_nxt = LAMP_RED;
        if (phase_nxt == PH_FAULT) begin
            if (flash_nxt >= FLASH_OFF) begin
                hwy_lamp_nxt  = LAMP_OFF;
                road_lamp_nxt = LAMP_OFF;
            end
        end else if (phase_nxt != PH_INIT) begin
            hwy_lamp_nxt  = decode_lamp(hwy);
            road_lamp_nxt = decode_lamp(road);
        end
    end

endmodule

// File: tb/tb_trafficlight_monitor.sv
// Bench for trafficlight_monitor: vector table, directed corner sequences, then random traffic vs a reference model.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// A summary line reports passed/total comparisons.
module tb_trafficlight_monitor;

    localparam int MINY = 3;
    localparam int FH   = 4;
    localparam int DW   = 8;
    localparam int DMAX = (1 << DW) - 1;

    logic          clock = 1'b0;
    logic          clear_n;
    logic [1:0]    hwy;
    logic [1:0]    road;
    logic          fault_ack;
    logic [2:0]    hwy_lamp;
    logic [2:0]    road_lamp;
    logic          fault;
    logic [2:0]    fault_code;
    logic [2:0]    phase;
    logic [DW-1:0] dwell;

    int n_total = 0;
    int n_pass  = 0;

    trafficlight_monitor #(.MIN_YELLOW(MINY), .FLASH_HALF(FH), .DWELL_W(DW)) dut (
        .clock(clock), .clear_n(clear_n), .hwy(hwy), .road(road), .fault_ack(fault_ack),
        .hwy_lamp(hwy_lamp), .road_lamp(road_lamp), .fault(fault), .fault_code(fault_code),
        .phase(phase), .dwell(dwell)
    );

    always #5 clock = ~clock;

    // Reference model: phases as integers, legal successor is (p+1)%5, flashing from elapsed fault cycles
    int pair_h[5] = '{1, 2, 0, 0, 0};
    int pair_r[5] = '{0, 0, 0, 1, 2};
    int m_phase, m_dwell, m_fault, m_code, m_fcyc, m_hl, m_rl;

    function automatic int lamp_of(input int c);
        if (c == 1) return 1;
        if (c == 2) return 2;
        return 4;
    endfunction

    function automatic int phase_of(input int h, input int r);
        for (int p = 0; p < 5; p++)
            if (pair_h[p] == h && pair_r[p] == r) return p;
        return -1;
    endfunction

    function automatic void model_reset();
        m_phase = 5; m_dwell = 0; m_fault = 0; m_code = 0; m_fcyc = 0; m_hl = 4; m_rl = 4;
    endfunction

    function automatic void model_step(input int h, input int r, input int ack);
        int pp;
        int det;
        if (m_fault != 0) begin
            if (ack != 0) begin
                m_fault = 0; m_code = 0; m_phase = 5; m_dwell = 0; m_fcyc = 0; m_hl = 4; m_rl = 4;
            end else begin
                m_fcyc = m_fcyc + 1;
                m_hl = (((m_fcyc / FH) % 2) == 0) ? 4 : 0;
                m_rl = m_hl;
            end
        end else begin
            pp  = phase_of(h, r);
            det = 0;
            if (h == 3 || r == 3) det = 1;
            else if (h != 0 && r != 0) det = 2;
            else if (m_phase != 5 && pp != m_phase) begin
                if (pp != (m_phase + 1) % 5) det = 3;
                else if ((m_phase == 1 || m_phase == 4) && m_dwell < MINY && m_dwell != DMAX) det = 4;
            end
            if (det != 0) begin
                m_fault = 1; m_code = det; m_phase = 6; m_dwell = 0; m_fcyc = 0; m_hl = 4; m_rl = 4;
            end else begin
                if (pp == m_phase) m_dwell = (m_dwell < DMAX) ? m_dwell + 1 : DMAX;
                else begin
                    m_phase = pp;
                    m_dwell = 1;
                end
                m_hl = lamp_of(h);
                m_rl = lamp_of(r);
            end
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".phase"}, int'(phase), m_phase);
        check({tag, ".dwell"}, int'(dwell), m_dwell);
        check({tag, ".fault"}, int'(fault), m_fault);
        check({tag, ".code"},  int'(fault_code), m_code);
        check({tag, ".hlamp"}, int'(hwy_lamp), m_hl);
        check({tag, ".rlamp"}, int'(road_lamp), m_rl);
    endtask

    task automatic step(input int h, input int r, input int ack);
        hwy = 2'(h); road = 2'(r); fault_ack = 1'(ack);
        @(posedge clock);
        #1;
        model_step(h, r, ack);
    endtask

    task automatic do_reset();
        fault_ack = 1'b0;
        #2 clear_n = 1'b0;
        model_reset();
        #2 clear_n = 1'b1;
    endtask

    typedef struct {
        int h, r, ack;
        int ph, dw, f, c, hl, rl;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input int h, input int r, input int ack, input int ph, input int dw,
                                input int f, input int c, input int hl, input int rl);
        vec_t v;
        v = '{h, r, ack, ph, dw, f, c, hl, rl};
        vecs.push_back(v);
    endfunction

    initial begin
        int idx;
        int sel;
        int h, r;

        // Legal cycle HG x5, HY x3, AR x2, RG x4, RY x3, HG, then a conflict with its flashing, ack, adopt RG
        for (int d = 1; d <= 5; d++) add(1, 0, 0, 0, d, 0, 0, 1, 4);
        for (int d = 1; d <= 3; d++) add(2, 0, 0, 1, d, 0, 0, 2, 4);
        for (int d = 1; d <= 2; d++) add(0, 0, 0, 2, d, 0, 0, 4, 4);
        for (int d = 1; d <= 4; d++) add(0, 1, 0, 3, d, 0, 0, 4, 1);
        for (int d = 1; d <= 3; d++) add(0, 2, 0, 4, d, 0, 0, 4, 2);
        add(1, 0, 0, 0, 1, 0, 0, 1, 4);
        add(1, 1, 0, 6, 0, 1, 2, 4, 4);
        for (int k = 1; k <= 8; k++) begin
            int l;
            l = (k < 4 || k == 8) ? 4 : 0;
            add(1, 1, 0, 6, 0, 1, 2, l, l);
        end
        add(1, 1, 1, 5, 0, 0, 0, 4, 4);
        add(0, 1, 0, 3, 1, 0, 0, 4, 1);

        // Reset state appears without a clock edge
        clear_n = 1'b1; hwy = 2'b00; road = 2'b00; fault_ack = 1'b0;
        #1 clear_n = 1'b0;
        model_reset();
        #1;
        check("reset.hlamp", int'(hwy_lamp), 4);
        check("reset.rlamp", int'(road_lamp), 4);
        check("reset.fault", int'(fault), 0);
        check("reset.code",  int'(fault_code), 0);
        check("reset.phase", int'(phase), 5);
        check("reset.dwell", int'(dwell), 0);
        @(negedge clock);
        clear_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].h, vecs[i].r, vecs[i].ack);
            check($sformatf("v%0d.phase", i), int'(phase), vecs[i].ph);
            check($sformatf("v%0d.dwell", i), int'(dwell), vecs[i].dw);
            check($sformatf("v%0d.fault", i), int'(fault), vecs[i].f);
            check($sformatf("v%0d.code", i),  int'(fault_code), vecs[i].c);
            check($sformatf("v%0d.hlamp", i), int'(hwy_lamp), vecs[i].hl);
            check($sformatf("v%0d.rlamp", i), int'(road_lamp), vecs[i].rl);
        end

        // Asynchronous reset mid-RG, between edges
        #2 clear_n = 1'b0;
        #1;
        check("midrst.hlamp", int'(hwy_lamp), 4);
        check("midrst.rlamp", int'(road_lamp), 4);
        check("midrst.fault", int'(fault), 0);
        check("midrst.phase", int'(phase), 5);
        model_reset();
        #2 clear_n = 1'b1;
        step(1, 0, 0);
        check("postrst.phase", int'(phase), 0);
        check("postrst.dwell", int'(dwell), 1);

        // Short yellow: HY x2 then AR
        step(2, 0, 0);
        step(2, 0, 0);
        step(0, 0, 0);
        check("shorty.fault", int'(fault), 1);
        check("shorty.code",  int'(fault_code), 4);
        check("shorty.phase", int'(phase), 6);
        step(0, 0, 1);
        // Full yellow: HY x3 then AR is legal
        step(1, 0, 0);
        step(2, 0, 0);
        step(2, 0, 0);
        step(2, 0, 0);
        step(0, 0, 0);
        check("fully.fault", int'(fault), 0);
        check("fully.phase", int'(phase), 2);

        // HG -> AR is illegal; a later encoding error must not overwrite the cause
        do_reset();
        step(1, 0, 0);
        step(0, 0, 0);
        check("skip.code", int'(fault_code), 3);
        step(0, 3, 0);
        check("sticky.code", int'(fault_code), 3);
        step(0, 3, 1);
        check("ack.fault", int'(fault), 0);
        check("ack.phase", int'(phase), 5);
        check("ack.dwell", int'(dwell), 0);
        step(0, 1, 0);
        check("adopt.phase", int'(phase), 3);
        check("adopt.fault", int'(fault), 0);

        // Encoding outranks conflict; ack outside FAULT does not stop the latch
        step(2, 3, 1);
        check("enc.fault", int'(fault), 1);
        check("enc.code",  int'(fault_code), 1);
        check("enc.hlamp", int'(hwy_lamp), 4);

        // Random traffic against the model
        do_reset();
        idx = 0;
        for (int n = 0; n < 4000; n++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 70) begin
                h = pair_h[idx]; r = pair_r[idx];
            end else if (sel < 90) begin
                idx = (idx + 1) % 5;
                h = pair_h[idx]; r = pair_r[idx];
            end else if (sel < 96) begin
                idx = int'($urandom_range(0, 4));
                h = pair_h[idx]; r = pair_r[idx];
            end else begin
                h = int'($urandom_range(0, 3));
                r = int'($urandom_range(0, 3));
            end
            step(h, r, ($urandom_range(0, 11) == 0) ? 1 : 0);
            check_model($sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
